ddr4_cmd_sched: RTL
===================

Name: ddr4_cmd_sched

Overview:
- Host-side DDR4 command scheduler that drives the DIMM emulator command pins (cs_n, act_n, A, bg, ba, cke).
- Accepts one read/write request at a time via a valid/ready interface and tracks the open row of every bank.
- Issues PRE/ACT/RD/WR under tRCD/tRAS/tRP/tCCD constraints, plus periodic precharge-all + REF.
- Honours the emulator's stall output; sits between the test/host traffic source and the DIMM top.

Parameters:
- BGWIDTH, 2, bank-group address width.
- BAWIDTH, 2, bank-per-group address width.
- ADDRWIDTH, 17, row address / A-bus width; must be ≥17 (A16..A14 double as ras_n/cas_n/we_n).
- COLWIDTH, 10, column width; must be ≤10 so the column never overlaps A10.
- T_RCD, 4, minimum cycles from ACT to RD/WR in the same bank.
- T_RAS, 10, minimum cycles from ACT to PRE in the same bank.
- T_RP, 4, minimum cycles from PRE to ACT in the same bank.
- T_CCD, 2, minimum cycles between any two RD/WR commands.
- T_RFC, 16, minimum cycles from REF to any next command.
- T_REFI, 64, refresh interval in cycles.
- Constraint: all timing parameters are in 1..255.

Ports:
- clk  in  1  scheduler clock; same clock that drives ck2x of the DIMM.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_wr  in  1  1 = write, 0 = read.
- req_bg  in  BGWIDTH  target bank group.
- req_ba  in  BAWIDTH  target bank.
- req_row  in  ADDRWIDTH  target row.
- req_col  in  COLWIDTH  target column.
- stall  in  1  from DIMM; while 1, no command is issued.
- cke  out  1  clock enable.
- cs_n  out  1  chip select (rank 0).
- act_n  out  1  activate.
- A  out  ADDRWIDTH  address / command bits.
- bg  out  BGWIDTH  bank group.
- ba  out  BAWIDTH  bank.
- busy  out  1  FSM not in IDLE or refresh pending.

Behaviour:
- Clock and reset: one clock (clk); reset_n is synchronous, active-low.
- Reset values: cke=0, cs_n=1, act_n=1, A=0, bg=0, ba=0, req_ready=0, busy=0; open-row table all invalid; all timers=0; refresh counter=0; FSM=IDLE.
- cke rises the first cycle after reset_n=1 and stays 1.
- All outputs are registered. A command occupies exactly one cycle with cs_n=0; every other cycle is deselect (cs_n=1, act_n=1, A/bg/ba hold last value).
- Command encodings (A16=ras_n, A15=cas_n, A14=we_n):
  - ACT: act_n=0, A=row.
  - RD: act_n=1, A16..14=101, A[COLWIDTH-1:0]=col, A10=0.
  - WR: same as RD with A16..14=100.
  - PRE: A16..14=010, A10=0.
  - PREA: A16..14=010, A10=1.
  - REF: A16..14=001.
  - Unused A bits = 0.
- req_ready=1 only in IDLE with no refresh pending, stall=0 and cke=1. An accepted request is latched; req_* are don't-care afterwards.
- FSM states: IDLE, PRE, ACT, CAS, RPREA, RWAIT, REF, RFC.
  - IDLE: refresh pending → RPREA. Otherwise, on accept: bank open with same row → CAS; bank open with different row → PRE; bank closed → ACT.
  - PRE: wait until the bank's tRAS has elapsed, issue PRE, mark bank closed → ACT.
  - ACT: wait until the bank's tRP has elapsed, issue ACT, record row → CAS.
  - CAS: wait until the bank's tRCD and global tCCD have elapsed, issue RD/WR → IDLE.
  - RPREA: wait until tRAS has elapsed in all open banks; if any bank is open, issue PREA and close all banks → RWAIT.
  - RWAIT: wait until tRP has elapsed in all banks → REF.
  - REF: issue REF, clear refresh pending → RFC.
  - RFC: wait T_RFC → IDLE.
- Timing semantics: a command at cycle t permits the constrained command at t+T_x at the earliest. Every eligible command is issued at the earliest legal cycle; no extra bubbles.
- Timers: per-bank rcd/ras/rp, global ccd/rfc; 8-bit saturating down-counters. They keep counting during stall.
- Row-hit latency: accept at cycle 0 → RD/WR at cycle 1 if timers allow. Closed bank: ACT at cycle 1, CAS at 1+T_RCD.
- Refresh counter: free-running, 16-bit. Sets refresh pending every T_REFI cycles and reloads. A pending refresh never aborts an in-flight request; it is serviced at the next IDLE. If a second interval expires while pending, it is not queued (pending stays 1).
- stall=1: FSM holds its state; a command due that cycle is deferred, with cs_n=1.
- reset_n=0 mid-sequence: the in-flight request is dropped and all state returns to reset values on that edge.
- busy = (state≠IDLE) | refresh pending.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles → cke=0, cs_n=1, req_ready=0. First cycle after release → cke=1. Second cycle → req_ready=1.
- Closed-bank read: req bg=1 ba=2 row=0x1234 col=0x08 accepted at cycle t → ACT (act_n=0, A=0x1234, bg=1, ba=2) at t+1; RD (A16..14=101, A[9:0]=0x008) at t+5.
- Row hit: write to the same row accepted right after the RD → WR at earliest RD+T_CCD=RD+2; no ACT.
- Row conflict: read row 0x0042 in the same bank right after its ACT at cycle a → PRE at a+10, ACT at a+14, RD at a+18.
- Refresh with bank open, T_REFI=64 → at the next IDLE: PREA (A10=1), REF T_RP later, req_ready=0 until REF+16, busy=1 throughout.
- Stall: assert stall for 5 cycles in the ACT state → no cs_n=0 during stall; ACT issued the cycle after stall drops; tRCD measured from the actual ACT.

Source files
------------

// File: rtl/ddr4_cmd_sched.sv
// rtl/ddr4_cmd_sched.sv - DDR4 host-side command scheduler (PRE/ACT/RD/WR, periodic PREA+REF)
// One request in flight; per-bank open-row table and timers gate every command.
module ddr4_cmd_sched #(
   parameter int BGWIDTH   = 2,
   parameter int BAWIDTH   = 2,
   parameter int ADDRWIDTH = 17,
   parameter int COLWIDTH  = 10,
   parameter int T_RCD     = 4,
   parameter int T_RAS     = 10,
   parameter int T_RP      = 4,
   parameter int T_CCD     = 2,
   parameter int T_RFC     = 16,
   parameter int T_REFI    = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_wr,
   input  logic [BGWIDTH-1:0]   req_bg,
   input  logic [BAWIDTH-1:0]   req_ba,
   input  logic [ADDRWIDTH-1:0] req_row,
   input  logic [COLWIDTH-1:0]  req_col,
   input  logic                 stall,
   output logic                 cke,
   output logic                 cs_n,
   output logic                 act_n,
   output logic [ADDRWIDTH-1:0] A,
   output logic [BGWIDTH-1:0]   bg,
   output logic [BAWIDTH-1:0]   ba,
   output logic                 busy
);
   localparam int BKW = BGWIDTH + BAWIDTH;
   localparam int NB  = 1 << BKW;
   localparam logic [7:0]  RCD_LD    = 8'(T_RCD - 1);
   localparam logic [7:0]  RAS_LD    = 8'(T_RAS - 1);
   localparam logic [7:0]  RP_LD     = 8'(T_RP - 1);
   localparam logic [7:0]  CCD_LD    = 8'(T_CCD - 1);
   localparam logic [7:0]  RFC_LD    = 8'(T_RFC - 1);
   localparam logic [15:0] REFI_LAST = 16'(T_REFI - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_ACT, S_CAS, S_RPREA, S_RWAIT, S_REF, S_RFC
   } state_t;

   typedef enum logic [2:0] {
      C_NONE, C_ACT, C_PRE, C_CAS, C_PREA, C_REF
   } cmd_t;

   state_t                 state_q, state_d;
   cmd_t                   cmd_d;
   logic                   pend_q, pend_d;
   logic [15:0]            refi_q;
   logic [NB-1:0]          open_q;
   logic [ADDRWIDTH-1:0]   row_q [NB];
   logic [7:0]             rcd_q [NB];
   logic [7:0]             ras_q [NB];
   logic [7:0]             rp_q  [NB];
   logic [7:0]             ccd_q, rfc_q;
   logic                   wr_q;
   logic [BKW-1:0]         bank_q;
   logic [ADDRWIDTH-1:0]   lrow_q;
   logic [COLWIDTH-1:0]    col_q;

   logic [BKW-1:0]         req_bank;
   logic                   accept;
   logic                   ras_ok_all, rp_ok_all;

   assign req_bank = {req_bg, req_ba};
   assign accept   = req_valid && req_ready && (state_q == S_IDLE);

   function automatic logic [ADDRWIDTH-1:0] cmd_bits(input logic [2:0] rcw, input logic a10,
                                                     input logic [COLWIDTH-1:0] col);
      logic [ADDRWIDTH-1:0] r;
      r                 = '0;
      r[COLWIDTH-1:0]   = col;
      r[10]             = a10;
      r[16:14]          = rcw;
      return r;
   endfunction

   // rp_ok_all looks one cycle ahead so REF lands exactly T_RP after PREA.
   always_comb begin
      ras_ok_all = 1'b1;
      rp_ok_all  = 1'b1;
      for (int i = 0; i < NB; i++) begin
         if (open_q[i] && ras_q[i] != 8'd0) ras_ok_all = 1'b0;
         if (rp_q[i] > 8'd1)                rp_ok_all  = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      cmd_d   = C_NONE;
      case (state_q)
         S_IDLE: begin
            if (pend_q)
               state_d = S_RPREA;
            else if (accept) begin
               if (!open_q[req_bank])                 state_d = S_ACT;
               else if (row_q[req_bank] == req_row)   state_d = S_CAS;
               else                                   state_d = S_PRE;
            end
         end
         S_PRE: if (!stall && ras_q[bank_q] == 8'd0 && rfc_q == 8'd0) begin
            cmd_d   = C_PRE;
            state_d = S_ACT;
         end
         S_ACT: if (!stall && rp_q[bank_q] == 8'd0 && rfc_q == 8'd0) begin
            cmd_d   = C_ACT;
            state_d = S_CAS;
         end
         S_CAS: if (!stall && rcd_q[bank_q] == 8'd0 && ccd_q == 8'd0 && rfc_q == 8'd0) begin
            cmd_d   = C_CAS;
            state_d = S_IDLE;
         end
         S_RPREA: if (!stall && ras_ok_all) begin
            if (|open_q) cmd_d = C_PREA;
            state_d = S_RWAIT;
         end
         S_RWAIT: if (!stall && rp_ok_all) state_d = S_REF;
         S_REF: if (!stall) begin
            cmd_d   = C_REF;
            pend_d  = 1'b0;
            state_d = S_RFC;
         end
         S_RFC: if (!stall && rfc_q == 8'd0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // An interval expiring while a refresh is still pending is simply absorbed.
      if (refi_q == REFI_LAST) pend_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         pend_q    <= 1'b0;
         refi_q    <= '0;
         open_q    <= '0;
         ccd_q     <= '0;
         rfc_q     <= '0;
         for (int i = 0; i < NB; i++) begin
            row_q[i] <= '0;
            rcd_q[i] <= '0;
            ras_q[i] <= '0;
            rp_q[i]  <= '0;
         end
         wr_q      <= 1'b0;
         bank_q    <= '0;
         lrow_q    <= '0;
         col_q     <= '0;
         cke       <= 1'b0;
         cs_n      <= 1'b1;
         act_n     <= 1'b1;
         A         <= '0;
         bg        <= '0;
         ba        <= '0;
         req_ready <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         refi_q    <= (refi_q == REFI_LAST) ? 16'd0 : refi_q + 16'd1;
         for (int i = 0; i < NB; i++) begin
            if (rcd_q[i] != 8'd0) rcd_q[i] <= rcd_q[i] - 8'd1;
            if (ras_q[i] != 8'd0) ras_q[i] <= ras_q[i] - 8'd1;
            if (rp_q[i]  != 8'd0) rp_q[i]  <= rp_q[i]  - 8'd1;
         end
         if (ccd_q != 8'd0) ccd_q <= ccd_q - 8'd1;
         if (rfc_q != 8'd0) rfc_q <= rfc_q - 8'd1;

         cke       <= 1'b1;
         req_ready <= (state_d == S_IDLE) && !pend_d && cke && !stall;
         busy      <= (state_d != S_IDLE) || pend_d;
         cs_n      <= 1'b1;
         act_n     <= 1'b1;

         if (accept) begin
            wr_q   <= req_wr;
            bank_q <= req_bank;
            lrow_q <= req_row;
            col_q  <= req_col;
         end

         // Later loads override the decrements above for the bank being commanded.
         case (cmd_d)
            C_ACT: begin
               cs_n          <= 1'b0;
               act_n         <= 1'b0;
               A             <= lrow_q;
               bg            <= bank_q[BKW-1:BAWIDTH];
               ba            <= bank_q[BAWIDTH-1:0];
               open_q[bank_q] <= 1'b1;
               row_q[bank_q] <= lrow_q;
               rcd_q[bank_q] <= RCD_LD;
               ras_q[bank_q] <= RAS_LD;
            end
            C_PRE: begin
               cs_n          <= 1'b0;
               A             <= cmd_bits(3'b010, 1'b0, '0);
               bg            <= bank_q[BKW-1:BAWIDTH];
               ba            <= bank_q[BAWIDTH-1:0];
               open_q[bank_q] <= 1'b0;
               rp_q[bank_q]  <= RP_LD;
            end
            C_CAS: begin
               cs_n          <= 1'b0;
               A             <= cmd_bits(wr_q ? 3'b100 : 3'b101, 1'b0, col_q);
               bg            <= bank_q[BKW-1:BAWIDTH];
               ba            <= bank_q[BAWIDTH-1:0];
               ccd_q         <= CCD_LD;
            end
            C_PREA: begin
               cs_n          <= 1'b0;
               A             <= cmd_bits(3'b010, 1'b1, '0);
               open_q        <= '0;
               for (int i = 0; i < NB; i++) rp_q[i] <= RP_LD;
            end
            C_REF: begin
               cs_n          <= 1'b0;
               A             <= cmd_bits(3'b001, 1'b0, '0);
               rfc_q         <= RFC_LD;
            end
            default: ;
         endcase
      end
   end
endmodule
